// File: rtl/nn_layer_sequencer.sv
// Time-multiplexed fully-connected layer controller: one signed MAC walks W·x row by row,
// then shift/saturate/activation, and streams each y element over valid/ready.
module nn_layer_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int MAX_DIM     = 64,
    parameter int DIM_W       = 7,
    parameter int WADDR_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DIM_W-1:0]       n_in,
    input  logic [DIM_W-1:0]       n_out,
    input  logic [WADDR_WIDTH-1:0] w_base,
    input  logic [1:0]             act_sel,
    input  logic [4:0]             shift,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   x_rd_en,
    output logic [DIM_W-1:0]       x_addr,
    input  logic [DATA_WIDTH-1:0]  x_data,
    output logic                   w_rd_en,
    output logic [WADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0]  w_data,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic [DATA_WIDTH-1:0]  y_data,
    output logic [DIM_W-1:0]       y_index
);

    // state | meaning
    // IDLE  | waiting for start; config sampled here only
    // READ  | one x/w read per cycle, products accumulate one cycle later
    // LAST  | final product of the row lands in acc
    // POST  | shift, saturate, activation -> y_data
    // OUT   | y_valid held until y_ready
    // DONE  | one-cycle done pulse
    typedef enum logic [2:0] {IDLE, READ, LAST, POST, OUT, DONE} state_t;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    state_t                         state;
    logic [DIM_W-1:0]               n_in_q;
    logic [DIM_W-1:0]               n_out_q;
    logic [DIM_W-1:0]               row;
    logic [1:0]                     act_q;
    logic [4:0]                     shift_q;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic                           rd_d;
    logic                           cfg_ok;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    shifted;
    logic [DATA_WIDTH-1:0]          post_val;

    assign cfg_ok   = (n_in != '0) && (n_in <= DIM_W'(MAX_DIM)) &&
                      (n_out != '0) && (n_out <= DIM_W'(MAX_DIM));
    assign prod     = $signed(x_data) * $signed(w_data);
    assign prod_ext = ACC_WIDTH'(prod);
    assign shifted  = acc >>> shift_q;

    always_comb begin
        post_val = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_MAX)
            post_val = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN)
            post_val = SAT_MIN[DATA_WIDTH-1:0];
        if (act_q == 2'b01 && shifted < 0)
            post_val = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            n_in_q  <= '0;
            n_out_q <= '0;
            row     <= '0;
            act_q   <= '0;
            shift_q <= '0;
            acc     <= '0;
            rd_d    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            x_rd_en <= 1'b0;
            w_rd_en <= 1'b0;
            x_addr  <= '0;
            w_addr  <= '0;
            y_valid <= 1'b0;
            y_data  <= '0;
            y_index <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            rd_d <= x_rd_en;
            if (rd_d)
                acc <= acc + prod_ext;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            n_in_q  <= n_in;
                            n_out_q <= n_out;
                            act_q   <= act_sel;
                            shift_q <= shift;
                            row     <= '0;
                            acc     <= '0;
                            x_addr  <= '0;
                            w_addr  <= w_base;
                            x_rd_en <= 1'b1;
                            w_rd_en <= 1'b1;
                            busy    <= 1'b1;
                            state   <= READ;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (x_addr == n_in_q - DIM_W'(1)) begin
                        x_rd_en <= 1'b0;
                        w_rd_en <= 1'b0;
                        state   <= LAST;
                    end else begin
                        x_addr <= x_addr + DIM_W'(1);
                        w_addr <= w_addr + WADDR_WIDTH'(1);
                    end
                end
                LAST: state <= POST;
                POST: begin
                    y_data  <= post_val;
                    y_index <= row;
                    y_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        if (row == n_out_q - DIM_W'(1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            // rows are contiguous, so the next row starts right after the last read
                            row     <= row + DIM_W'(1);
                            acc     <= '0;
                            x_addr  <= '0;
                            w_addr  <= w_addr + WADDR_WIDTH'(1);
                            x_rd_en <= 1'b1;
                            w_rd_en <= 1'b1;
                            state   <= READ;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: directed and randomized layers checked against a
// plain-arithmetic model of y = act(sat((W·x) >>> shift)) plus cycle-timing formulas.
module tb_nn_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  n_in;
    logic [6:0]  n_out;
    logic [11:0] w_base;
    logic [1:0]  act_sel;
    logic [4:0]  shift;
    logic        busy, done, err;
    logic        x_rd_en, w_rd_en;
    logic [6:0]  x_addr;
    logic [11:0] w_addr;
    logic [15:0] x_data, w_data;
    logic        y_valid, y_ready;
    logic [15:0] y_data;
    logic [6:0]  y_index;

    logic signed [15:0] x_mem [128];
    logic signed [15:0] w_mem [4096];
    logic [15:0] got_y [64];
    int checks = 0;
    int errors = 0;
    int last_done;

    nn_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .n_in(n_in), .n_out(n_out),
        .w_base(w_base), .act_sel(act_sel), .shift(shift), .busy(busy),
        .done(done), .err(err), .x_rd_en(x_rd_en), .x_addr(x_addr),
        .x_data(x_data), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_index(y_index)
    );

    always #5 clk = ~clk;

    // synchronous-read buffers: data appears the cycle after the strobe
    always @(posedge clk) begin
        if (x_rd_en) x_data <= x_mem[x_addr];
        if (w_rd_en) w_data <= w_mem[w_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_y(input int ni, input int wb, input int r,
                                          input logic [1:0] act, input int sh);
        longint acc = 0;
        longint v;
        for (int c = 0; c < ni; c++)
            acc += longint'(x_mem[c]) * longint'(w_mem[(wb + r*ni + c) % 4096]);
        v = acc >>> sh;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        if (act == 2'b01 && v < 0) v = 0;
        return 16'(v);
    endfunction

    // rmode: 0 always ready, 1 random ready, 2 ready low for 5 cycles at row 0
    task automatic run_layer(input int ni, input int no, input int wb, input logic [1:0] act,
                             input int sh, input int rmode, input bit overlap);
        int  cyc = 0, rd_cnt = 0, out_cnt = 0, stalls = 0, stall5 = 0;
        bit  fin = 0, prev_valid = 0;
        @(negedge clk);
        n_in = 7'(ni); n_out = 7'(no); w_base = 12'(wb); act_sel = act; shift = 5'(sh);
        start = 1'b1;
        y_ready = 1'b1;
        while (!fin && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (overlap && cyc == 2) begin
                start = 1'b1;
                n_in = 7'($urandom_range(1, 64)); n_out = 7'($urandom_range(1, 64));
                w_base = 12'($urandom); act_sel = 2'($urandom); shift = 5'($urandom);
            end
            check("busy_run", busy, 1);
            if (x_rd_en) begin
                check("x_addr", x_addr, rd_cnt % ni);
                check("w_addr", w_addr, (wb + (rd_cnt / ni) * ni + rd_cnt % ni) % 4096);
                check("w_rd_en", w_rd_en, 1);
                rd_cnt++;
            end
            if (y_valid) begin
                if (!prev_valid)
                    check("out_cycle", cyc, out_cnt*(ni+3) + ni + 3 + stalls);
                check("no_read_in_out", x_rd_en, 0);
                check("y_index", y_index, out_cnt);
                check("y_data", y_data, ref_y(ni, wb, out_cnt, act, sh));
                case (rmode)
                    0: y_ready = 1'b1;
                    1: y_ready = ($urandom_range(0, 2) != 0);
                    default: y_ready = !(out_cnt == 0 && stall5 < 5);
                endcase
                if (y_ready) begin
                    got_y[out_cnt] = y_data;
                    out_cnt++;
                    prev_valid = 0;
                end else begin
                    stalls++;
                    stall5++;
                    prev_valid = 1;
                end
            end else begin
                prev_valid = 0;
                y_ready = (rmode == 1) ? 1'($urandom) : 1'b1;
            end
            if (done) begin
                check("done_cycle", cyc, no*(ni+3) + 1 + stalls);
                check("rows_out", out_cnt, no);
                check("reads", rd_cnt, ni*no);
                last_done = cyc;
                fin = 1;
            end
        end
        if (!fin) check("timeout", 0, 1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_end", busy, 0);
        y_ready = 1'b1;
    endtask

    task automatic check_illegal(input int ni, input int no);
        @(negedge clk);
        n_in = 7'(ni); n_out = 7'(no); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_rd", x_rd_en, 0);
        @(negedge clk);
        check("err_once", err, 0);
        check("err_busy2", busy, 0);
        check("err_rd2", x_rd_en | w_rd_en, 0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; n_in = '0; n_out = '0; w_base = '0;
        act_sel = '0; shift = '0; y_ready = 1'b0;
        for (int i = 0; i < 128; i++) x_mem[i] = '0;
        for (int i = 0; i < 4096; i++) w_mem[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_outs", {busy, done, err, x_rd_en, w_rd_en, y_valid}, 0);
        check("rst_data", {y_data, y_index, x_addr, w_addr}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", {busy, done, err, x_rd_en, w_rd_en, y_valid}, 0);

        // worked example
        x_mem[0] = 1; x_mem[1] = 2; x_mem[2] = 3;
        w_mem[0] = 1; w_mem[1] = 1; w_mem[2] = 1; w_mem[3] = -1; w_mem[4] = 0; w_mem[5] = 2;
        run_layer(3, 2, 0, 2'b01, 0, 0, 0);
        check("ex_y0", got_y[0], 16'd6);
        check("ex_y1", got_y[1], 16'd5);
        check("ex_done", last_done, 13);

        // negative row under ReLU and pass-through
        w_mem[100] = -2; w_mem[101] = -1; w_mem[102] = 0;
        run_layer(3, 1, 100, 2'b01, 0, 0, 0);
        check("neg_relu", got_y[0], 16'h0000);
        run_layer(3, 1, 100, 2'b00, 0, 0, 0);
        check("neg_pass", got_y[0], 16'hFFFC);

        // saturation
        for (int i = 0; i < 4; i++) begin x_mem[i] = 32767; w_mem[200+i] = 32767; end
        run_layer(4, 1, 200, 2'b00, 17, 0, 0);
        check("sat_shift17", got_y[0], 16'd32766);
        run_layer(4, 1, 200, 2'b00, 0, 0, 0);
        check("sat_pos", got_y[0], 16'd32767);
        x_mem[0] = -32768; w_mem[300] = 32767;
        run_layer(1, 1, 300, 2'b10, 0, 0, 0);
        check("sat_neg", got_y[0], 16'h8000);
        run_layer(1, 1, 300, 2'b01, 0, 0, 0);
        check("sat_relu", got_y[0], 16'h0000);

        // backpressure: same layer with and without a 5-cycle stall
        for (int i = 0; i < 6; i++) x_mem[i] = 16'($urandom);
        for (int i = 0; i < 18; i++) w_mem[400+i] = 16'($urandom);
        run_layer(6, 3, 400, 2'b00, 3, 0, 0);
        d0 = last_done;
        run_layer(6, 3, 400, 2'b00, 3, 2, 0);
        check("stall_delay", last_done, d0 + 5);

        // illegal configs and overlapping start
        check_illegal(0, 2);
        check_illegal(3, 65);
        check_illegal(5, 0);
        run_layer(6, 3, 400, 2'b01, 2, 0, 1);

        // weight address wrap
        for (int i = 0; i < 4; i++) w_mem[(4094+i) % 4096] = 16'($urandom);
        run_layer(4, 1, 4094, 2'b00, 0, 0, 0);

        // reset mid-READ, then a clean rerun
        @(negedge clk);
        n_in = 7'd4; n_out = 7'd2; w_base = 12'd50; act_sel = 2'b00; shift = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_rd", x_rd_en, 1);
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_rd", x_rd_en, 0);
        check("rst_valid", y_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) w_mem[50+i] = 16'($urandom);
        run_layer(4, 2, 50, 2'b00, 0, 1, 0);

        // randomized layers
        for (int t = 0; t < 8; t++) begin
            int ni = $urandom_range(1, 8);
            int no = $urandom_range(1, 4);
            int wb = $urandom_range(0, 4095);
            for (int c = 0; c < ni; c++) x_mem[c] = 16'($urandom);
            for (int k = 0; k < ni*no; k++) w_mem[(wb + k) % 4096] = 16'($urandom);
            run_layer(ni, no, wb, 2'($urandom), $urandom_range(0, 31), 1, t[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
